fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V pipeline: owns the PC, issues in-order requests to instruction memory, buffers returned words in a small prefetch queue, and presents them to the decode stage with the `op`/`funct3`/`funct7` fields the control decoder consumes. It handles redirects (taken branch, `jal`, `jalr`) from execute by flushing the queue and discarding in-flight responses.

---
 rtl/riscv_pkg.sv | 49 ++++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RISC-V definitions: data width, the opcodes the
//                control decoder switches on, the canonical NOP, the fetch
//                queue entry layout and instruction field slice helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN = 32;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One prefetch queue slot: fetch address plus the word returned for it
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [6:0] get_opcode(input logic [XLEN-1:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [2:0] get_funct3(input logic [XLEN-1:0] instr);
        return instr[14:12];
    endfunction

    // Only bit 30 of funct7 distinguishes add/sub and srl/sra for the decoder
    function automatic logic get_funct7b5(input logic [XLEN-1:0] instr);
        return instr[30];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
//  Module      : fetch_fifo
//  Description : DEPTH x 64-bit synchronous FIFO holding {pc, instr} pairs
//                between instruction memory and decode. Flush wins over push.
//                Push and pop together on a full FIFO are accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [2*XLEN-1:0]          wdata,
    output logic [2*XLEN-1:0]          rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [2*XLEN-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_depth);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    // A push into a full FIFO is only taken when the head leaves in the same cycle
    assign w_do_pop  = pop  && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage write; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (rst_n && !flush && w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the fetch PC, issues in-order
//                credit-limited requests to instruction memory, buffers the
//                returned words and presents them to decode. Redirects flush
//                the queue and discard every response still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    // instruction memory
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [XLEN-1:0]  imem_rdata,
    // redirect from execute
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    // decode stage
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_instr,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_pcplus4,
    output logic [6:0]       id_op,
    output logic [2:0]       id_funct3,
    output logic             id_funct7
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [XLEN-1:0] r_fpc;          // next address to request
    logic [XLEN-1:0] r_rpc;          // address belonging to the next kept response
    logic [CW-1:0]   r_outstanding;  // granted, not yet returned
    logic [CW-1:0]   r_discard;      // returns still to be thrown away

    logic            w_grant;
    logic            w_keep;
    logic            w_pop;
    logic            w_credit;
    logic [CW-1:0]   w_out_next;
    logic [XLEN-1:0] w_target;

    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;
    logic [2*XLEN-1:0] w_fifo_rdata;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;

    // Credit counts both buffered words and requests in flight, so every
    // granted request is guaranteed a queue slot when it returns
    assign w_credit  = ((r_outstanding + w_count) < c_depth) && !w_full;
    assign imem_req  = rst_n && w_credit;
    assign imem_addr = rst_n ? r_fpc : RESET_PC;

    assign w_grant    = imem_req && imem_gnt;
    assign w_keep     = imem_rvalid && (r_discard == '0) && !redirect;
    assign w_pop      = id_valid && id_ready;
    assign w_out_next = r_outstanding + CW'(w_grant) - CW'(imem_rvalid);
    assign w_target   = redirect_pc & ~32'd3;

    assign w_push_entry.pc    = r_rpc;
    assign w_push_entry.instr = imem_rdata;

    // PC, response-PC and in-flight bookkeeping; a redirect rebases both PCs
    // and marks everything still outstanding (including this cycle's grant) stale
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fpc         <= RESET_PC;
            r_rpc         <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect) begin
                r_fpc     <= w_target;
                r_rpc     <= w_target;
                r_discard <= w_out_next;
            end else begin
                if (w_grant) r_fpc <= r_fpc + 32'd4;
                if (w_keep)  r_rpc <= r_rpc + 32'd4;
                if (imem_rvalid && (r_discard != '0)) r_discard <= r_discard - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_keep),
        .pop   (w_pop),
        .flush (redirect),
        .wdata (w_push_entry),
        .rdata (w_fifo_rdata),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_head = fetch_entry_t'(w_fifo_rdata);

    // Data outputs are forced to zero whenever nothing valid is presented
    assign id_valid   = rst_n && !w_empty;
    assign id_instr   = id_valid ? w_head.instr : '0;
    assign id_pc      = id_valid ? w_head.pc    : '0;
    assign id_pcplus4 = id_valid ? (w_head.pc + 32'd4) : '0;
    assign id_op      = get_opcode(id_instr);
    assign id_funct3  = get_funct3(id_instr);
    assign id_funct7  = get_funct7b5(id_instr);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A zero-wait memory model
//                returns the address as data; kept responses are pushed to a
//                scoreboard and compared when decode accepts them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pcplus4;
    logic [6:0]  id_op;
    logic [2:0]  id_funct3;
    logic        id_funct7;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pcplus4  (id_pcplus4),
        .id_op       (id_op),
        .id_funct3   (id_funct3),
        .id_funct7   (id_funct7)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } mem_t;

    mem_t        mem_q[$];     // granted requests awaiting response
    logic [31:0] exp_q[$];     // scoreboard: PCs expected at decode, in order
    logic [31:0] grant_log[$]; // granted addresses since last redirect/reset
    logic [31:0] pop_log[$];   // id_pc values accepted since last redirect/reset
    logic [31:0] exp_fpc = RESET_PC;
    bit          last_rd;
    logic [31:0] held;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Hold reset for n cycles, checking the reset-time output values
    task automatic reset_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
            redirect = 1'b0; id_ready = 1'b0;
            mem_q.delete(); exp_q.delete(); grant_log.delete(); pop_log.delete();
            exp_fpc = RESET_PC;
            #1;
            chk("rst_imem_req",   32'(imem_req),   32'h0);
            chk("rst_imem_addr",  imem_addr,       RESET_PC);
            chk("rst_id_valid",   32'(id_valid),   32'h0);
            chk("rst_id_instr",   id_instr,        32'h0);
            chk("rst_id_pc",      id_pc,           32'h0);
            chk("rst_id_pcplus4", id_pcplus4,      32'h0);
            chk("rst_id_fields",  {22'h0, id_op, id_funct3}, 32'h0);
            chk("rst_id_funct7",  32'(id_funct7),  32'h0);
        end
    endtask

    // One clock of stimulus: check invariants, drive memory/decode/redirect, update model
    task automatic step(input bit g, input bit rdy, input bit rs, input bit rd,
                        input bit rd_cond, input logic [31:0] rpc);
        mem_t        e;
        bit          keep;
        bit          resp;
        bit          rd_eff;
        logic        req_s;
        logic [31:0] addr_s;
        logic [31:0] head;
        logic        exp_req;
        @(negedge clk);
        if (!rst_n) begin
            rst_n = 1'b1;
            #1;
        end
        req_s   = imem_req;
        addr_s  = imem_addr;
        exp_req = ((mem_q.size() + exp_q.size()) < DEPTH);
        chk("imem_req", 32'(req_s), 32'(exp_req));
        chk("id_valid", 32'(id_valid), 32'(exp_q.size() > 0));
        if (req_s) chk("imem_addr", addr_s, exp_fpc);

        resp   = rs && (mem_q.size() > 0);
        rd_eff = rd && (!rd_cond || (req_s && g && resp));
        last_rd = rd_eff;
        imem_gnt    = g;
        id_ready    = rdy;
        redirect    = rd_eff;
        redirect_pc = rpc;
        keep = 1'b0;
        if (resp) begin
            e = mem_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = e.addr;
            keep = !e.stale && !rd_eff;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end

        if (id_valid && rdy && (exp_q.size() > 0)) begin
            head = exp_q.pop_front();
            pop_log.push_back(id_pc);
            chk("id_pc",      id_pc,      head);
            chk("id_instr",   id_instr,   head);
            chk("id_pcplus4", id_pcplus4, head + 32'd4);
            chk("id_op",      32'(id_op),     32'(head[6:0]));
            chk("id_funct3",  32'(id_funct3), 32'(head[14:12]));
            chk("id_funct7",  32'(id_funct7), 32'(head[30]));
        end
        if (keep) exp_q.push_back(e.addr);
        if (rd_eff) begin
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            exp_q.delete();
            grant_log.delete();
            pop_log.delete();
        end
        if (req_s && g) begin
            mem_q.push_back('{addr: addr_s, stale: rd_eff});
            if (!rd_eff) grant_log.push_back(addr_s);
        end
        if (rd_eff)          exp_fpc = rpc & ~32'd3;
        else if (req_s && g) exp_fpc = exp_fpc + 32'd4;
    endtask

    task automatic run(input int n, input bit g, input bit rdy, input bit rs);
        repeat (n) step(g, rdy, rs, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        // Reset, then streaming from RESET_PC
        reset_cycles(3);
        run(8, 1'b1, 1'b1, 1'b1);
        chk("start_grant_cnt", 32'(grant_log.size() >= 3), 32'h1);
        chk("start_grant0", grant_log[0], 32'h0);
        chk("start_grant1", grant_log[1], 32'h4);
        chk("start_grant2", grant_log[2], 32'h8);
        chk("start_pop0",   pop_log[0],   32'h0);

        // Decode stall: queue fills, requests stop, head held
        run(2, 1'b1, 1'b0, 1'b1);
        chk("stall_valid", 32'(id_valid), 32'h1);
        held = id_instr;
        repeat (3) begin
            run(1, 1'b1, 1'b0, 1'b1);
            chk("stall_hold", id_instr, held);
        end
        chk("stall_req_low", 32'(imem_req), 32'h0);
        run(8, 1'b1, 1'b1, 1'b1);

        // Two outstanding, then redirect to an unaligned target
        run(4, 1'b0, 1'b1, 1'b1);
        run(2, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0103);
        run(10, 1'b1, 1'b1, 1'b1);
        chk("redir_grant0", grant_log[0], 32'h0000_0100);
        chk("redir_pops",   32'(pop_log.size() > 0), 32'h1);
        chk("redir_pop0",   pop_log[0], 32'h0000_0100);

        // Redirect coinciding with a grant and a response
        last_rd = 1'b0;
        for (int i = 0; i < 6 && !last_rd; i++)
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        chk("both_hit", 32'(last_rd), 32'h1);
        run(1, 1'b1, 1'b1, 1'b1);
        chk("both_no_stale_valid", 32'(id_valid), 32'h0);
        run(8, 1'b1, 1'b1, 1'b1);
        chk("both_grant0", grant_log[0], 32'h0000_0200);
        chk("both_pop0",   pop_log[0],   32'h0000_0200);

        // Address wrap at the top of the address space
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF8);
        run(10, 1'b1, 1'b1, 1'b1);
        chk("wrap_cnt",    32'(grant_log.size() >= 3), 32'h1);
        chk("wrap_grant0", grant_log[0], 32'hFFFF_FFF8);
        chk("wrap_grant1", grant_log[1], 32'hFFFF_FFFC);
        chk("wrap_grant2", grant_log[2], 32'h0000_0000);

        // Reset with the queue full, then refetch from RESET_PC
        run(4, 1'b1, 1'b0, 1'b1);
        chk("full_valid",   32'(id_valid), 32'h1);
        chk("full_req_low", 32'(imem_req), 32'h0);
        reset_cycles(1);
        run(8, 1'b1, 1'b1, 1'b1);
        chk("rerst_grant0", grant_log[0], RESET_PC);
        chk("rerst_pop0",   pop_log[0],   RESET_PC);

        run(4, 1'b0, 1'b1, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
